// File: rtl/fifo_v3.sv
// fifo_v3: register-based synchronous FIFO with optional fall-through and flush.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic [DATA_WIDTH-1:0],
    localparam int unsigned ADDR_DEPTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  dtype                  data_i,
    input  logic                  push_i,
    output dtype                  data_o,
    input  logic                  pop_i
);
    localparam int unsigned FIFO_DEPTH = (DEPTH > 0) ? DEPTH : 1;
    localparam logic [ADDR_DEPTH:0]   FULL_CNT = (ADDR_DEPTH + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_DEPTH-1:0] LAST_PTR = ADDR_DEPTH'(FIFO_DEPTH - 1);
    logic [ADDR_DEPTH-1:0] read_ptr_q, write_ptr_q, read_ptr_d, write_ptr_d;
    logic [ADDR_DEPTH:0]   status_cnt_q, status_cnt_d;
    dtype                  mem_q [FIFO_DEPTH];
    logic                  bypass, do_push, do_pop, unused_testmode;
    assign unused_testmode = testmode_i;
    always_comb begin
        full_o       = status_cnt_q == FULL_CNT;
        empty_o      = (status_cnt_q == '0) && !(FALL_THROUGH && push_i);
        usage_o      = status_cnt_q[ADDR_DEPTH-1:0];
        bypass       = FALL_THROUGH && (status_cnt_q == '0) && push_i;
        data_o       = bypass ? data_i : mem_q[read_ptr_q];
        // A fall-through word that is popped immediately never touches storage.
        do_push      = push_i && !full_o && !(bypass && pop_i);
        do_pop       = pop_i && !empty_o && !bypass;
        write_ptr_d  = do_push ? ((write_ptr_q == LAST_PTR) ? '0 : write_ptr_q + 1'b1) : write_ptr_q;
        read_ptr_d   = do_pop ? ((read_ptr_q == LAST_PTR) ? '0 : read_ptr_q + 1'b1) : read_ptr_q;
        status_cnt_d = status_cnt_q + (ADDR_DEPTH + 1)'(do_push) - (ADDR_DEPTH + 1)'(do_pop);
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            read_ptr_q   <= '0;
            write_ptr_q  <= '0;
            status_cnt_q <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            read_ptr_q   <= '0;
            write_ptr_q  <= '0;
            status_cnt_q <= '0;
        end else begin
            read_ptr_q   <= read_ptr_d;
            write_ptr_q  <= write_ptr_d;
            status_cnt_q <= status_cnt_d;
            if (do_push) mem_q[write_ptr_q] <= data_i;
        end
    end
`ifndef SYNTHESIS
    depth_legal: assert property (@(posedge clk_i) DEPTH > 0)
        else $error("fifo_v3: DEPTH must be greater than zero");
    push_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_o))
        else $warning("fifo_v3: push while full dropped");
    pop_empty: assert property (@(posedge clk_i) disable iff (rst_i) !(pop_i && empty_o))
        else $warning("fifo_v3: pop while empty ignored");
`endif
endmodule

// File: tb/tb_fifo_v3.sv
// tb_fifo_v3: randomized scoreboard bench for fifo_v3 plus directed depth-3 and fall-through checks.
module tb_fifo_v3;
    logic clk = 0, rst = 1, flush = 0, push = 0, pop = 0;
    logic [7:0] din = 0, dout;
    logic full, empty;
    logic [1:0] usage;
    logic p3 = 0, q3 = 0, f3_full, f3_empty;
    logic [7:0] d3 = 0, dout3;
    logic [1:0] usage3;
    logic pf = 0, qf = 0, ff_full, ff_empty;
    logic [7:0] df = 0, doutf;
    logic [1:0] usagef;
    int vec = 0, errs = 0;
    logic [7:0] m[$], expq[$], m3[$];

    always #5 clk = ~clk;

    fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(4)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .testmode_i(1'b0),
        .full_o(full), .empty_o(empty), .usage_o(usage),
        .data_i(din), .push_i(push), .data_o(dout), .pop_i(pop));
    fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .flush_i(1'b0), .testmode_i(1'b0),
        .full_o(f3_full), .empty_o(f3_empty), .usage_o(usage3),
        .data_i(d3), .push_i(p3), .data_o(dout3), .pop_i(q3));
    fifo_v3 #(.FALL_THROUGH(1'b1), .DATA_WIDTH(8), .DEPTH(4)) dutf (
        .clk_i(clk), .rst_i(rst), .flush_i(1'b0), .testmode_i(1'b1),
        .full_o(ff_full), .empty_o(ff_empty), .usage_o(usagef),
        .data_i(df), .push_i(pf), .data_o(doutf), .pop_i(qf));

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    // Monitor: every accepted pop of the main FIFO must present the next scoreboard entry.
    always @(negedge clk) begin
        if (!rst && !flush && pop && !empty) begin
            if (expq.size() == 0) begin
                vec++;
                errs++;
                $display("FAIL sb_pop: DUT popped %0h with no expected entry", dout);
            end else chk("data_o", 32'(dout), 32'(expq.pop_front()));
        end
    end

    task automatic step(input logic p, input logic q, input logic [7:0] d, input logic f);
        push = p; pop = q; din = d; flush = f;
        if (!f && q && m.size() > 0) expq.push_back(m[0]);
        @(negedge clk);
        chk("usage_o", 32'(usage), 32'(m.size() % 4));
        chk("full_o", 32'(full), 32'(m.size() == 4));
        chk("empty_o", 32'(empty), 32'(m.size() == 0));
        if (f) m.delete();
        else begin
            bit ap = p && m.size() < 4;
            if (q && m.size() > 0) void'(m.pop_front());
            if (ap) m.push_back(d);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_usage", 32'(usage), 0);
        chk("rst_data", 32'(dout), 0);
        chk("rst_empty3", 32'(f3_empty), 1);
        chk("rst_dataf", 32'(doutf), 0);
        @(posedge clk); #1;
        for (int i = 1; i <= 4; i++) step(1, 0, 8'hA0 + 8'(i), 0);
        step(1, 0, 8'hFF, 0);
        chk("full_head", 32'(dout), 32'hA1);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) step(1, 0, 8'hA0 + 8'(i), 0);
        step(1, 1, 8'hB0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < 400; i++) begin
            logic f = ($urandom_range(0, 39) == 0);
            step(1'($urandom), f ? 1'b0 : 1'($urandom), 8'($urandom), f);
        end
        step(0, 0, 0, 1);
        step(1, 0, 8'h11, 0);
        step(1, 0, 8'h22, 0);
        step(1, 0, 8'h33, 1);
        step(0, 0, 0, 0);
        step(1, 0, 8'h44, 0);
        step(1, 0, 8'h55, 0);
        push = 0;
        rst = 1;
        @(posedge clk); #1 rst = 0;
        m.delete();
        @(negedge clk);
        chk("midrst_data", 32'(dout), 0);
        chk("midrst_empty", 32'(empty), 1);
        chk("midrst_usage", 32'(usage), 0);
        @(posedge clk); #1;
        chk("sb_drained", 32'(expq.size()), 0);
        for (int i = 1; i <= 12; i++) begin
            p3 = (i <= 10); q3 = (i > 2); d3 = 8'(i);
            @(negedge clk);
            chk("usage3", 32'(usage3), 32'(m3.size()));
            chk("full3", 32'(f3_full), 32'(m3.size() == 3));
            if (q3) chk("data3", 32'(dout3), 32'(m3[0]));
            if (q3) void'(m3.pop_front());
            if (p3) m3.push_back(d3);
            @(posedge clk); #1;
        end
        p3 = 0; q3 = 0;
        @(negedge clk);
        chk("empty3_end", 32'(f3_empty), 1);
        @(posedge clk); #1;
        pf = 1; qf = 1; df = 8'h5A;
        @(negedge clk);
        chk("ft_data", 32'(doutf), 32'h5A);
        chk("ft_empty", 32'(ff_empty), 0);
        @(posedge clk); #1 pf = 0; qf = 0;
        @(negedge clk);
        chk("ft_after_empty", 32'(ff_empty), 1);
        chk("ft_after_usage", 32'(usagef), 0);
        @(posedge clk); #1 pf = 1; df = 8'h5B;
        @(negedge clk);
        chk("ft_push_data", 32'(doutf), 32'h5B);
        @(posedge clk); #1 pf = 0;
        @(negedge clk);
        chk("ft_stored_usage", 32'(usagef), 1);
        chk("ft_stored_data", 32'(doutf), 32'h5B);
        chk("ft_stored_empty", 32'(ff_empty), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
